// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIV sequencer with a start/busy/done handshake.
// It computes one bit per clock: a shift-add multiply or a restoring divide.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             abort,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StMulRun, StDivRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               dbz_q, dbz_d;

    // MUL: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // DIV: acc = {partial remainder, remaining dividend bits / quotient bits}
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic               last;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_ge    = ~div_diff[WIDTH+1];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};
    assign last      = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start && !abort) begin
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (!op) begin
                        state_d = StMulRun;
                        acc_d   = {{WIDTH{1'b0}}, op2};
                        opnd_d  = op1;
                    end else if (op2 == '0) begin
                        // Divide by zero completes immediately without ever going busy
                        state_d  = StDone;
                        res_lo_d = '1;
                        res_hi_d = op1;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = StDivRun;
                        acc_d   = {{WIDTH{1'b0}}, op1};
                        opnd_d  = op2;
                    end
                end
            end
            StMulRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d  = StDone;
                        res_lo_d = mul_next[WIDTH-1:0];
                        res_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    end
                end
            end
            StDivRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d  = StDone;
                        res_lo_d = div_next[WIDTH-1:0];
                        res_hi_d = div_next[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == StMulRun) || (state_q == StDivRun);
    assign done        = (state_q == StDone);
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; a scoreboard of expected results is filled
// at issue time and drained on each done pulse.
module tb_muldiv_sequencer;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, op, abort;
    logic [W-1:0] op1, op2;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .abort       (abort),
        .op1         (op1),
        .op2         (op2),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        if (!o) begin
            p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.lo  = p[W-1:0];
            e.hi  = p[2*W-1:W];
            e.dbz = 1'b0;
        end else if (b == '0) begin
            e.lo  = '1;
            e.hi  = a;
            e.dbz = 1'b1;
        end else begin
            e.lo  = a / b;
            e.hi  = a % b;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the start edge E0.
    task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        if (push) push_exp(o, a, b);
        @(negedge clk);
        start = 1'b0;
        op    = 1'(~o);
        op1   = W'($urandom);
        op2   = W'($urandom);
    endtask

    // lat counts edges after E0 until done is visible (0 means visible right after E0).
    task automatic wait_done(input string tag, input int exp_lat, input logic exp_busy);
        int   lat;
        exp_t e;
        lat = 0;
        check({tag, "_busy_e0"}, 32'(busy), 32'(exp_busy));
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_lo"}, 32'(result_lo), 32'(e.lo));
            check({tag, "_hi"}, 32'(result_hi), 32'(e.hi));
            check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        end
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        abort = 1'b0;
        op1   = '0;
        op2   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lo", 32'(result_lo), 32'd0);
        check("rst_hi", 32'(result_hi), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: MUL 3*5
        issue(1'b0, 16'd3, 16'd5, 1'b1);
        wait_done("t1", 16, 1'b1);
        @(negedge clk);
        check("t1_pulse_end", 32'(done), 32'd0);

        // 2: MUL 0xFFFF*0xFFFF
        issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("t2", 16, 1'b1);
        @(negedge clk);
        check("t2_pulse_end", 32'(done), 32'd0);

        // 3: DIV 100/7
        issue(1'b1, 16'd100, 16'd7, 1'b1);
        wait_done("t3", 16, 1'b1);
        @(negedge clk);
        check("t3_pulse_end", 32'(done), 32'd0);

        // 4: DIV by zero
        issue(1'b1, 16'h1234, 16'h0000, 1'b1);
        wait_done("t4", 0, 1'b0);
        @(negedge clk);
        check("t4_pulse_end", 32'(done), 32'd0);

        // 5: MUL, ignored start at E0+5, abort at E0+8
        issue(1'b0, 16'd3, 16'd5, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        op1   = 16'd9;
        op2   = 16'd2;
        @(negedge clk);
        start = 1'b0;
        check("t5_busy_ignored", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy_abort", 32'(busy), 32'd0);
        check("t5_done_abort", 32'(done), 32'd0);
        check("t5_lo_held", 32'(result_lo), 32'hFFFF);
        check("t5_hi_held", 32'(result_hi), 32'h1234);
        seen = 0;
        repeat (24) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("t5_no_done", 32'(seen), 32'd0);

        // 6: back-to-back MUL 6*7 then DIV 50/5, then reset mid-DIV
        issue(1'b0, 16'd6, 16'd7, 1'b1);
        wait_done("t6_mul", 16, 1'b1);
        issue(1'b1, 16'd50, 16'd5, 1'b1);
        check("t6_b2b_done_low", 32'(done), 32'd0);
        wait_done("t6_div", 16, 1'b1);
        @(negedge clk);
        issue(1'b1, 16'd1000, 16'd3, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_lo", 32'(result_lo), 32'd0);
        check("t6_rst_hi", 32'(result_hi), 32'd0);
        check("t6_rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_after_rst_done", 32'(done), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
